// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3-stage 3x3 signed-weight convolution with bias, shift and 0..255 clamp,
// flagging only windows fully inside the image and the last output of each frame.
module conv3x3_mac #(
    parameter int MAX_WIDTH  = 128,
    parameter int MAX_HEIGHT = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  stage_width,
    input  logic [7:0]  stage_height,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [7:0]  win1,
    input  logic [7:0]  win2,
    input  logic [7:0]  win3,
    input  logic [7:0]  win4,
    input  logic [7:0]  win5,
    input  logic [7:0]  win6,
    input  logic [7:0]  win7,
    input  logic [7:0]  win8,
    input  logic [7:0]  win9,
    input  logic        wt_we,
    input  logic [3:0]  wt_addr,
    input  logic [15:0] wt_data,
    input  logic [3:0]  shift,
    output logic [7:0]  pix_out,
    output logic        pix_out_valid,
    output logic        pix_out_last
);
    localparam int CW = $clog2(MAX_WIDTH);
    localparam int RW = $clog2(MAX_HEIGHT);

    logic [CW-1:0]      r_col, w_col;
    logic [RW-1:0]      r_row, w_row;
    logic               w_col_end, w_row_end, w_win_ok, w_win_last;
    logic signed [7:0]  r_wt [9];
    logic signed [15:0] r_bias;
    logic [7:0]         w_win [9];
    logic signed [16:0] w_prod [9];
    logic signed [16:0] r_prod [9];
    logic signed [21:0] w_sum, r_sum, w_y;
    logic [7:0]         w_clamp;
    logic               r_v1, r_l1, r_v2, r_l2;

    // frame_start marks the current beat as (0,0), so it overrides the stored position
    always_comb begin
        w_col      = frame_start ? '0 : r_col;
        w_row      = frame_start ? '0 : r_row;
        w_col_end  = 32'(w_col) == 32'(stage_width) - 32'd1;
        w_row_end  = 32'(w_row) == 32'(stage_height) - 32'd1;
        w_win_ok   = pixel_valid && stage_width >= 8'd3 && stage_height >= 8'd3 &&
                     32'(w_col) >= 32'd2 && 32'(w_row) >= 32'd2;
        w_win_last = w_win_ok && w_col_end && w_row_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pixel_valid) begin
            r_col <= w_col_end ? '0 : w_col + CW'(1);
            r_row <= w_col_end ? (w_row_end ? '0 : w_row + RW'(1)) : w_row;
        end else if (frame_start) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) r_wt[k] <= '0;
            r_bias <= '0;
        end else if (wt_we) begin
            for (int k = 0; k < 9; k++)
                if (wt_addr == 4'(k)) r_wt[k] <= wt_data[7:0];
            if (wt_addr == 4'd9) r_bias <= wt_data;
        end
    end

    always_comb begin
        w_win = '{win1, win2, win3, win4, win5, win6, win7, win8, win9};
        for (int k = 0; k < 9; k++)
            w_prod[k] = 17'(signed'({1'b0, w_win[k]})) * 17'(r_wt[k]);
    end

    always_comb begin
        w_sum = 22'(r_bias);
        for (int k = 0; k < 9; k++) w_sum = w_sum + 22'(r_prod[k]);
    end

    always_comb begin
        w_y     = r_sum >>> shift;
        w_clamp = w_y < 22'sd0 ? 8'd0 : w_y > 22'sd255 ? 8'd255 : w_y[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) r_prod[k] <= '0;
            r_sum         <= '0;
            r_v1          <= 1'b0;
            r_l1          <= 1'b0;
            r_v2          <= 1'b0;
            r_l2          <= 1'b0;
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            pix_out_last  <= 1'b0;
        end else begin
            for (int k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
            r_sum         <= w_sum;
            r_v1          <= w_win_ok;
            r_l1          <= w_win_last;
            r_v2          <= r_v1;
            r_l2          <= r_l1;
            pix_out_valid <= r_v2;
            pix_out_last  <= r_v2 & r_l2;
            if (r_v2) pix_out <= w_clamp;
        end
    end
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: directed vector table over 4x4 frames plus hand sequences for gaps,
// restarts, small dimensions, coefficient write timing and asynchronous reset.
module tb_conv3x3_mac;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  stage_width = 8'd4;
    logic [7:0]  stage_height = 8'd4;
    logic        frame_start = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [7:0]  win [9];
    logic        wt_we = 1'b0;
    logic [3:0]  wt_addr = '0;
    logic [15:0] wt_data = '0;
    logic [3:0]  shift = '0;
    logic [7:0]  pix_out;
    logic        pix_out_valid, pix_out_last;

    typedef struct {
        logic [8:0][7:0] w;
        logic [15:0]     bias;
        logic [3:0]      sh;
        int              pmode;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t tv [5];
    int   checks = 0, errors = 0;
    int   cyc = 0, beat_cyc = 0, pmode = 0;
    int   q_val[$], q_last[$], q_cyc[$];

    conv3x3_mac dut (
        .clk(clk), .rst_n(rst_n), .stage_width(stage_width), .stage_height(stage_height),
        .frame_start(frame_start), .pixel_valid(pixel_valid),
        .win1(win[0]), .win2(win[1]), .win3(win[2]), .win4(win[3]), .win5(win[4]),
        .win6(win[5]), .win7(win[6]), .win8(win[7]), .win9(win[8]),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data), .shift(shift),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .pix_out_last(pix_out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (pix_out_valid) begin
            q_val.push_back(int'(pix_out));
            q_last.push_back(int'(pix_out_last));
            q_cyc.push_back(cyc);
        end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_at(input int r, input int c);
        if (r < 0 || c < 0) return 8'd0;
        return pmode == 0 ? 8'(4 * r + c) : 8'(pmode);
    endfunction

    task automatic idle();
        @(negedge clk);
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        wt_we       = 1'b0;
    endtask

    task automatic drain();
        repeat (6) idle();
    endtask

    task automatic clear_q();
        q_val.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        @(negedge clk);
        wt_we   = 1'b1;
        wt_addr = 4'(a);
        wt_data = d;
        idle();
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < 9; k++) wr(k, {{8{v.w[k][7]}}, v.w[k]});
        wr(9, v.bias);
        shift = v.sh;
        pmode = v.pmode;
    endtask

    // Drives pixels in raster order with windows built as the line-buffer collector would.
    task automatic run_frame(input int w, input int h, input bit fs, input int gap,
                             input int npix, input bit wr_last);
        int n;
        n = 0;
        stage_width  = 8'(w);
        stage_height = 8'(h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if (n < npix) begin
                    if (gap > 0)
                        while ($urandom_range(0, 99) < gap) idle();
                    @(negedge clk);
                    pixel_valid = 1'b1;
                    frame_start = fs && n == 0;
                    wt_we       = 1'b0;
                    for (int k = 0; k < 9; k++) win[k] = pix_at(r - 2 + k / 3, c - 2 + k % 3);
                    if (wr_last && n == npix - 1) begin
                        wt_we   = 1'b1;
                        wt_addr = 4'd4;
                        wt_data = 16'd2;
                    end
                    if (r == 2 && c == 2) beat_cyc = cyc;
                    n++;
                end
        idle();
    endtask

    task automatic check_frame(input string nm, input logic [3:0][7:0] exp, input int n);
        chk({nm, " count"}, q_val.size(), n);
        for (int i = 0; i < n && i < q_val.size(); i++) begin
            chk($sformatf("%s val%0d", nm, i), q_val[i], exp[i]);
            chk($sformatf("%s last%0d", nm, i), q_last[i], i == n - 1);
        end
        clear_q();
    endtask

    initial begin
        for (int k = 0; k < 9; k++) win[k] = '0;
        tv[0] = '{w: '0, bias: 16'd0, sh: 4'd0, pmode: 0, exp: {8'd10, 8'd9, 8'd6, 8'd5}};
        tv[0].w[4] = 8'd1;
        tv[1] = '{w: {9{8'd1}}, bias: 16'd0, sh: 4'd3, pmode: 255, exp: {4{8'd255}}};
        tv[2] = '{w: '0, bias: 16'd0, sh: 4'd0, pmode: 100, exp: {4{8'd0}}};
        tv[2].w[4] = 8'hFF;
        tv[3] = '{w: '0, bias: 16'hFFCE, sh: 4'd0, pmode: 100, exp: {4{8'd50}}};
        tv[3].w[4] = 8'd1;
        tv[4] = '{w: '0, bias: 16'd300, sh: 4'd1, pmode: 7, exp: {4{8'd150}}};

        #12;
        chk("reset pix_out", pix_out, 0);
        chk("reset valid", pix_out_valid, 0);
        chk("reset last", pix_out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            load(tv[t]);
            clear_q();
            run_frame(4, 4, 1'b1, 0, 16, 1'b0);
            drain();
            if (t == 0) chk("latency", q_cyc.size() > 0 ? q_cyc[0] - beat_cyc : -1, 3);
            check_frame($sformatf("vec%0d", t), tv[t].exp, 4);
        end

        load(tv[0]);
        clear_q();
        run_frame(4, 4, 1'b1, 30, 9, 1'b0);
        @(negedge clk);
        pixel_valid = 1'b0;
        frame_start = 1'b1;
        idle();
        run_frame(4, 4, 1'b0, 30, 16, 1'b0);
        drain();
        check_frame("gap idle-restart", tv[0].exp, 4);
        run_frame(4, 4, 1'b1, 0, 9, 1'b0);
        run_frame(4, 4, 1'b1, 40, 16, 1'b0);
        drain();
        check_frame("gap beat-restart", tv[0].exp, 4);

        run_frame(2, 4, 1'b1, 0, 8, 1'b0);
        drain();
        check_frame("width2", '0, 0);
        run_frame(4, 2, 1'b1, 0, 8, 1'b0);
        drain();
        check_frame("height2", '0, 0);

        run_frame(3, 3, 1'b1, 0, 9, 1'b1);
        drain();
        check_frame("wr same cycle", 32'd5, 1);
        run_frame(3, 3, 1'b1, 0, 9, 1'b0);
        drain();
        check_frame("wr next frame", 32'd10, 1);

        run_frame(4, 4, 1'b1, 0, 16, 1'b0);
        for (int i = 0; i < 4 && !pix_out_valid; i++) idle();
        chk("inflight valid", pix_out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async pix_out", pix_out, 0);
        chk("async valid", pix_out_valid, 0);
        chk("async last", pix_out_last, 0);
        repeat (2) @(negedge clk);
        clear_q();
        rst_n = 1'b1;
        repeat (8) idle();
        check_frame("post reset stale", '0, 0);
        run_frame(4, 4, 1'b1, 0, 16, 1'b0);
        drain();
        check_frame("post reset weights", '0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
